// File: rtl/sync_fifo_v2.sv
// Single-clock byte FIFO with registered read data and full/empty flags.
// Optional sticky overflow/underflow outputs are enabled by defining SYNC_FIFO_V2_ERR_FLAGS_EN.
module sync_fifo_v2 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  rd_acc;
  logic                  wr_acc;

  // The extra MSB distinguishes a full buffer from an empty one when the addresses match.
  assign empty  = (wptr == rptr);
  assign full   = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                  (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
  assign rd_acc = read_enable & ~empty;
  assign wr_acc = write_enable & (~full | rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (wr_acc) begin
      wptr <= wptr + PTR_ONE;
    end
  end

  // Read stage: data_out only moves on an accepted read, otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr     <= '0;
      data_out <= '0;
    end else if (rd_acc) begin
      rptr     <= rptr + PTR_ONE;
      data_out <= mem[rptr[ADDR_WIDTH-1:0]];
    end
  end

`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable && full && !read_enable) begin
        overflow <= 1'b1;
      end
      if (read_enable && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed self-checking bench for sync_fifo_v2: reset, burst, fill, empty read,
// simultaneous read/write and pointer wrap-around.
module tb_sync_fifo_v2;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int errors = 0;
  int checks = 0;

  sync_fifo_v2 #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty)
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1ns after the next rising edge.
  task automatic do_op(input logic we, input logic re, input logic [7:0] din);
    @(negedge clk);
    write_enable = we;
    read_enable  = re;
    data_in      = din;
    @(posedge clk);
    #1;
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b1, 1'b0, 8'h42);
    do_op(1'b1, 1'b0, 8'h43);
    do_op(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'h42 || empty !== 1'b0) begin
      errors++; $display("FAIL pre_async data=%h empty=%b exp=42 0", data_out, empty);
    end
    // Reset mid-cycle, well away from any rising edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL async_reset empty=%b full=%b data=%h exp=1 0 00", empty, full, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_burst();
    logic [7:0] vec [10];
    vec = '{8'h11, 8'h23, 8'h36, 8'h75, 8'h21, 8'h99, 8'hAB, 8'hFE, 8'h48, 8'hFF};
    for (int i = 0; i < 10; i++) begin
      do_op(1'b1, 1'b0, vec[i]);
      checks++;
      if (full !== 1'b0 || empty !== 1'b0) begin
        errors++; $display("FAIL burst_wr%0d full=%b empty=%b exp=0 0", i, full, empty);
      end
    end
    for (int i = 0; i < 10; i++) begin
      do_op(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== vec[i]) begin
        errors++; $display("FAIL burst_rd%0d got=%h exp=%h", i, data_out, vec[i]);
      end
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL burst_empty got=%b exp=1", empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      do_op(1'b1, 1'b0, 8'(i));
      if (i == 14) begin
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL fill_15_full got=%b exp=0", full); end
      end
    end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL fill_16_full got=%b exp=1", full); end
    do_op(1'b1, 1'b0, 8'hAA);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL fill_17_full got=%b exp=1", full); end
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow got=%b exp=1", overflow); end
`endif
    for (int i = 0; i < 16; i++) begin
      do_op(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== 8'(i)) begin
        errors++; $display("FAIL fill_rd%0d got=%h exp=%h", i, data_out, 8'(i));
      end
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL fill_drained empty=%b full=%b exp=1 0", empty, full);
    end
  endtask

  task automatic test_read_empty();
    do_op(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'h0F || empty !== 1'b1) begin
      errors++; $display("FAIL rd_empty data=%h empty=%b exp=0f 1", data_out, empty);
    end
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL underflow got=%b exp=1", underflow); end
`endif
    do_op(1'b1, 1'b0, 8'h77);
    do_op(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'h77 || empty !== 1'b1) begin
      errors++; $display("FAIL rd_empty_ptr data=%h empty=%b exp=77 1", data_out, empty);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) do_op(1'b1, 1'b0, 8'(8'h10 + i));
    do_op(1'b1, 1'b1, 8'h5A);
    checks++;
    if (full !== 1'b1 || data_out !== 8'h10) begin
      errors++; $display("FAIL rw_full full=%b data=%h exp=1 10", full, data_out);
    end
    for (int i = 1; i < 16; i++) begin
      do_op(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== 8'(8'h10 + i)) begin
        errors++; $display("FAIL rw_full_rd%0d got=%h exp=%h", i, data_out, 8'(8'h10 + i));
      end
    end
    do_op(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'h5A || empty !== 1'b1) begin
      errors++; $display("FAIL rw_full_last data=%h empty=%b exp=5a 1", data_out, empty);
    end
    do_op(1'b1, 1'b1, 8'h3C);
    checks++;
    if (data_out !== 8'h5A || empty !== 1'b0) begin
      errors++; $display("FAIL rw_empty data=%h empty=%b exp=5a 0", data_out, empty);
    end
    do_op(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'h3C || empty !== 1'b1) begin
      errors++; $display("FAIL rw_empty_rd data=%h empty=%b exp=3c 1", data_out, empty);
    end
  endtask

  task automatic test_wrap();
    do_op(1'b1, 1'b0, 8'h80);
    for (int i = 1; i < 40; i++) begin
      do_op(1'b1, 1'b1, 8'(8'h80 + i));
      checks++;
      if (data_out !== 8'(8'h80 + i - 1) || empty !== 1'b0 || full !== 1'b0) begin
        errors++; $display("FAIL wrap%0d data=%h empty=%b full=%b exp=%h 0 0",
                           i, data_out, empty, full, 8'(8'h80 + i - 1));
      end
    end
    do_op(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'hA7 || empty !== 1'b1) begin
      errors++; $display("FAIL wrap_last data=%h empty=%b exp=a7 1", data_out, empty);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    data_in      = 8'h00;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    test_reset();
    test_burst();
    test_fill();
    test_read_empty();
    test_simultaneous();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
